// File: rtl/axi_lite_pkt_buffer.sv
// AXI-Lite slave front-end: DATA/STATUS/CTRL registers over a circular-buffer packet FIFO.
// Define PKT_CHECK_EN to reject DATA writes whose top byte differs from MAGIC.
module axi_lite_pkt_buffer #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         ADDR_WIDTH  = 8,
    parameter int         BUFFER_SIZE = 16,
    parameter logic [7:0] MAGIC       = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         aw_addr,
    input  logic                          aw_valid,
    output logic                          aw_ready,
    input  logic [DATA_WIDTH-1:0]         w_data,
    input  logic                          w_valid,
    output logic                          w_ready,
    output logic [1:0]                    b_resp,
    output logic                          b_valid,
    input  logic                          b_ready,
    input  logic [ADDR_WIDTH-1:0]         ar_addr,
    input  logic                          ar_valid,
    output logic                          ar_ready,
    output logic [DATA_WIDTH-1:0]         r_data,
    output logic [1:0]                    r_resp,
    output logic                          r_valid,
    input  logic                          r_ready,
    output logic [$clog2(BUFFER_SIZE):0]  fifo_count,
    output logic                          not_empty
);

    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = PW + 1;
    localparam int IW = ADDR_WIDTH - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [IW-1:0] IDX_DATA   = IW'(0);
    localparam logic [IW-1:0] IDX_STATUS = IW'(1);
    localparam logic [IW-1:0] IDX_CTRL   = IW'(2);

    localparam logic [CW-1:0] FULL_COUNT = CW'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        SEL_DATA,
        SEL_STATUS,
        SEL_CTRL,
        SEL_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode(input logic [IW-1:0] idx);
        if (idx == IDX_DATA)        return SEL_DATA;
        else if (idx == IDX_STATUS) return SEL_STATUS;
        else if (idx == IDX_CTRL)   return SEL_CTRL;
        else                        return SEL_NONE;
    endfunction

    // Storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [15:0]           drop_count;

    logic                  aw_held;
    logic [IW-1:0]         aw_idx_q;
    logic                  w_held;
    logic [DATA_WIDTH-1:0] w_data_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [IW-1:0]         wr_idx;
    logic [DATA_WIDTH-1:0] wr_word;
    reg_sel_e              wr_sel;
    reg_sel_e              rd_sel;
    logic                  magic_ok;
    logic                  empty;
    logic                  full;

    logic [1:0]            wr_resp;
    logic                  push;
    logic                  drop;
    logic                  flush;
    logic [1:0]            rd_resp;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  pop;
    logic [DATA_WIDTH-1:0] status_word;

    logic                  unused_bits;
    assign unused_bits = ^{aw_addr[1:0], ar_addr[1:0], MAGIC};

    // Readys are forced low while reset is held so every output reads 0.
    assign aw_ready = !rst && !aw_held && !b_valid;
    assign w_ready  = !rst && !w_held && !b_valid;
    assign ar_ready = !rst && !r_valid;

    assign aw_hs  = aw_valid && aw_ready;
    assign w_hs   = w_valid && w_ready;
    assign ar_hs  = ar_valid && ar_ready;
    assign commit = (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_idx  = aw_held ? aw_idx_q : aw_addr[ADDR_WIDTH-1:2];
    assign wr_word = w_held ? w_data_q : w_data;
    assign wr_sel  = decode(wr_idx);
    assign rd_sel  = decode(ar_addr[ADDR_WIDTH-1:2]);

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign fifo_count = count;

`ifdef PKT_CHECK_EN
    assign magic_ok = (wr_word[DATA_WIDTH-1 -: 8] == MAGIC);
`else
    assign magic_ok = 1'b1;
`endif

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_resp = RESP_OKAY;
        push    = 1'b0;
        drop    = 1'b0;
        flush   = 1'b0;
        if (commit) begin
            case (wr_sel)
                SEL_DATA: begin
                    if (full || !magic_ok) begin
                        wr_resp = RESP_SLVERR;
                        drop    = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                SEL_STATUS: wr_resp = RESP_SLVERR;
                SEL_CTRL:   flush   = wr_word[0];
                default:    wr_resp = RESP_DECERR;
            endcase
        end
    end

    always_comb begin
        status_word        = '0;
        status_word[0]     = empty;
        status_word[1]     = full;
        status_word[15:8]  = 8'(count);
        status_word[31:16] = drop_count;
    end

    // Read response is built from pre-edge state; a flush on the same edge suppresses the pop.
    always_comb begin
        rd_resp = RESP_OKAY;
        rd_word = '0;
        pop     = 1'b0;
        case (rd_sel)
            SEL_DATA: begin
                if (empty) begin
                    rd_resp = RESP_SLVERR;
                end else begin
                    rd_word = mem[rd_ptr];
                    pop     = ar_hs && !flush;
                end
            end
            SEL_STATUS: rd_word = status_word;
            SEL_CTRL:   rd_word = '0;
            default:    rd_resp = RESP_DECERR;
        endcase
    end

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held  <= 1'b0;
            aw_idx_q <= '0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                b_valid <= 1'b1;
                b_resp  <= wr_resp;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= aw_addr[ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= w_data;
                end
                if (b_valid && b_ready)
                    b_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
        end else if (ar_hs) begin
            r_valid <= 1'b1;
            r_data  <= rd_word;
            r_resp  <= rd_resp;
        end else if (r_valid && r_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            not_empty  <= 1'b0;
            drop_count <= '0;
        end else begin
            count     <= count_next;
            not_empty <= (count_next != '0);
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                drop_count <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (drop && drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end
        end
    end

    // NOTE: the storage array has no reset; only the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_word;
    end

endmodule

// File: tb/tb_axi_lite_pkt_buffer.sv
// Randomized self-checking bench for axi_lite_pkt_buffer against a queue-based reference model.
// Directed sequences cover reset, split AW/W, full/empty, same-edge push/pop and flush.
module tb_axi_lite_pkt_buffer;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BS = 16;
    localparam int TMO = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] aw_addr;
    logic          aw_valid;
    logic          aw_ready;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic [1:0]    b_resp;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] ar_addr;
    logic          ar_valid;
    logic          ar_ready;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          r_valid;
    logic          r_ready;
    logic [4:0]    fifo_count;
    logic          not_empty;

    always #5 clk = ~clk;

    axi_lite_pkt_buffer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BUFFER_SIZE(BS),
        .MAGIC      (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .aw_addr   (aw_addr),
        .aw_valid  (aw_valid),
        .aw_ready  (aw_ready),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .b_resp    (b_resp),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .ar_addr   (ar_addr),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .r_data    (r_data),
        .r_resp    (r_resp),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .fifo_count(fifo_count),
        .not_empty (not_empty)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus a saturating drop counter.
    logic [31:0] mq[$];
    int          drops;

    function automatic void compute_write(input logic [7:0] a, input logic [31:0] d,
                                          output logic [1:0] resp, output bit push,
                                          output bit drop, output bit flush);
        bit ok;
        ok = 1'b1;
`ifdef PKT_CHECK_EN
        ok = (d[31:24] == 8'hA5);
`endif
        resp = 2'b00; push = 1'b0; drop = 1'b0; flush = 1'b0;
        case (a[7:2])
            6'd0: begin
                if (mq.size() >= BS || !ok) begin
                    resp = 2'b10;
                    drop = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            6'd1:    resp = 2'b10;
            6'd2:    flush = d[0];
            default: resp = 2'b11;
        endcase
    endfunction

    function automatic void compute_read(input logic [7:0] a, output logic [31:0] d,
                                         output logic [1:0] resp, output bit pop);
        d = '0; resp = 2'b00; pop = 1'b0;
        case (a[7:2])
            6'd0: begin
                if (mq.size() == 0) begin
                    resp = 2'b10;
                end else begin
                    d   = mq[0];
                    pop = 1'b1;
                end
            end
            6'd1: d = (32'(drops) << 16) | (32'(mq.size()) << 8) |
                      ((mq.size() == BS) ? 32'h2 : 32'h0) | ((mq.size() == 0) ? 32'h1 : 32'h0);
            6'd2: d = '0;
            default: resp = 2'b11;
        endcase
    endfunction

    function automatic void apply(input bit push, input logic [31:0] d, input bit drop,
                                  input bit pop, input bit flush);
        if (flush) begin
            mq.delete();
            drops = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d);
            if (drop && drops < 65535) drops++;
        end
    endfunction

    task automatic check_level(input string tag);
        check({tag, "_count"}, fifo_count, mq.size());
        check({tag, "_not_empty"}, not_empty, mq.size() != 0);
    endtask

    // All drive tasks start and end just after a falling edge.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int aw_dly,
                            input int w_dly, input int b_dly, output logic [1:0] resp);
        logic [1:0] exp_r;
        bit push, drop, flush;
        int t;
        compute_write(a, d, exp_r, push, drop, flush);
        fork
            begin : aw_side
                int ta;
                ta = 0;
                repeat (aw_dly) @(negedge clk);
                aw_addr = a; aw_valid = 1'b1;
                while (!aw_ready && ta < TMO) begin @(negedge clk); ta++; end
                @(negedge clk);
                aw_valid = 1'b0;
                if (ta >= TMO) check("aw_timeout", 1, 0);
            end
            begin : w_side
                int tw;
                tw = 0;
                repeat (w_dly) @(negedge clk);
                w_data = d; w_valid = 1'b1;
                while (!w_ready && tw < TMO) begin @(negedge clk); tw++; end
                @(negedge clk);
                w_valid = 1'b0;
                if (tw >= TMO) check("w_timeout", 1, 0);
            end
        join
        t = 0;
        while (!b_valid && t < TMO) begin @(negedge clk); t++; end
        check("b_latency", t, 0);
        repeat (b_dly) begin
            @(negedge clk);
            check("b_hold", {b_valid, b_resp}, {1'b1, exp_r});
        end
        resp = b_resp;
        check("b_resp", b_resp, exp_r);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check("b_clear", b_valid, 0);
        apply(push, d, drop, 1'b0, flush);
        check_level("wr");
    endtask

    task automatic do_read(input logic [7:0] a, input int r_dly, output logic [31:0] got);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        bit pop;
        int t;
        compute_read(a, exp_d, exp_r, pop);
        ar_addr = a; ar_valid = 1'b1;
        t = 0;
        while (!ar_ready && t < TMO) begin @(negedge clk); t++; end
        @(negedge clk);
        ar_valid = 1'b0;
        if (t >= TMO) check("ar_timeout", 1, 0);
        check("r_latency", r_valid, 1);
        repeat (r_dly) begin
            @(negedge clk);
            check("r_hold", r_valid, 1);
        end
        got = r_data;
        check("r_data", r_data, exp_d);
        check("r_resp", r_resp, exp_r);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check("r_clear", r_valid, 0);
        apply(1'b0, '0, 1'b0, pop, 1'b0);
        check_level("rd");
    endtask

    // Write commit and read accept on the same rising edge.
    task automatic do_both(input logic [7:0] wa, input logic [31:0] wd, input logic [7:0] ra);
        logic [31:0] exp_d;
        logic [1:0]  exp_wr, exp_rr;
        bit push, drop, flush, pop;
        compute_write(wa, wd, exp_wr, push, drop, flush);
        compute_read(ra, exp_d, exp_rr, pop);
        check("both_ready", {aw_ready, w_ready, ar_ready}, 3'b111);
        aw_addr = wa; aw_valid = 1'b1; w_data = wd; w_valid = 1'b1;
        ar_addr = ra; ar_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        check("both_b", {b_valid, b_resp}, {1'b1, exp_wr});
        check("both_r", {r_valid, r_resp}, {1'b1, exp_rr});
        check("both_r_data", r_data, exp_d);
        apply(push, wd, drop, pop, flush);
        check_level("both");
        b_ready = 1'b1; r_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0; r_ready = 1'b0;
        check("both_clear", {b_valid, r_valid}, 2'b00);
    endtask

    // AW alone at cycle 0, W at cycle 3, b_ready held off for two cycles.
    task automatic split_write(input logic [31:0] d);
        logic [1:0] exp_r;
        bit push, drop, flush;
        compute_write(8'h00, d, exp_r, push, drop, flush);
        aw_addr = 8'h00; aw_valid = 1'b1;
        check("split_aw_ready", aw_ready, 1);
        @(negedge clk);
        aw_valid = 1'b0;
        repeat (2) begin
            check("split_no_b", b_valid, 0);
            check("split_aw_block", aw_ready, 0);
            @(negedge clk);
        end
        w_data = d; w_valid = 1'b1;
        check("split_w_ready", w_ready, 1);
        @(negedge clk);
        w_valid = 1'b0;
        check("split_commit", {b_valid, b_resp}, {1'b1, exp_r});
        check("split_w_block", w_ready, 0);
        repeat (2) begin
            @(negedge clk);
            check("split_b_hold", {b_valid, b_resp}, {1'b1, exp_r});
            check("split_readys_low", {aw_ready, w_ready}, 2'b00);
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        check("split_b_clear", b_valid, 0);
        check("split_w_free", w_ready, 1);
        apply(push, d, drop, 1'b0, flush);
        check_level("split");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp, not_empty}, 0);
        check({tag, "_r_data"}, r_data, 0);
        check({tag, "_count"}, fifo_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [1:0]  resp;
        logic [7:0]  a;
        logic [31:0] d;
        int          sel;
        int          op;

        rst = 1'b1;
        aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_valid = 1'b0; b_ready = 1'b0;
        ar_addr = '0; ar_valid = 1'b0; r_ready = 1'b0;
        mq.delete();
        drops = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {aw_ready, w_ready, ar_ready}, 3'b111);

        // Three DATA writes then STATUS
        for (int i = 1; i <= 3; i++) begin
            do_write(8'h00, 32'hA500_0000 + i, 0, 0, 0, resp);
            check("seq_bresp", resp, 2'b00);
        end
        do_read(8'h04, 0, got);
        check("seq_status", got, 32'h0000_0300);
        check("seq_count", fifo_count, 3);

        split_write(32'hA500_0004);

        // Flush, fill to full, overflow, drain, underflow
        do_write(8'h08, 32'h1, 0, 0, 0, resp);
        check("flush_count", fifo_count, 0);
        for (int i = 0; i < BS; i++)
            do_write(8'h00, 32'hA510_0000 + i, $urandom_range(0, 2), $urandom_range(0, 2), 0, resp);
        do_write(8'h00, 32'hA5FF_FFFF, 0, 0, 1, resp);
        check("overflow_resp", resp, 2'b10);
        do_read(8'h04, 0, got);
        check("full_status", got, 32'h0001_1002);
        for (int i = 0; i < BS; i++)
            do_read(8'h00, $urandom_range(0, 2), got);
        do_read(8'h00, 0, got);
        check("underflow_data", got, 0);
        check("underflow_count", fifo_count, 0);

        // Same-edge push/pop at empty, mid-level and full
        do_both(8'h00, 32'hA520_0000, 8'h00);
        for (int i = 1; i < 5; i++) do_write(8'h00, 32'hA520_0000 + i, 0, 0, 0, resp);
        do_both(8'h00, 32'hA520_0005, 8'h00);
        check("pushpop_count5", fifo_count, 5);
        while (mq.size() < BS) do_write(8'h00, 32'hA530_0000 + mq.size(), 0, 0, 0, resp);
        do_both(8'h00, 32'hA5EE_EEEE, 8'h00);
        check("full_pushpop_count", fifo_count, BS - 1);
        do_both(8'h08, 32'h1, 8'h00);
        check("flush_over_pop", fifo_count, 0);

        // Flush then unmapped and CTRL reads
        for (int i = 0; i < 3; i++) do_write(8'h00, 32'hA540_0000 + i, 0, 0, 0, resp);
        do_write(8'h00, 32'hA540_0009, 0, 0, 0, resp);
        do_write(8'h08, 32'h1, 0, 0, 0, resp);
        do_read(8'h0C, 0, got);
        check("unmapped_resp", dut.r_resp, 2'b11);
        do_read(8'h04, 0, got);
        check("post_flush_status", got, 32'h0000_0001);
        do_read(8'h0B, 0, got);
        check("ctrl_read", got, 0);
        do_write(8'h05, 32'hFFFF_FFFF, 0, 0, 0, resp);
        check("status_write_resp", resp, 2'b10);

`ifdef PKT_CHECK_EN
        do_write(8'h00, 32'h1234_5678, 0, 0, 0, resp);
        check("magic_reject_resp", resp, 2'b10);
        do_read(8'h04, 0, got);
        check("magic_drop_count", got[31:16], 1);
`endif

        // Reset while an AW is held
        for (int i = 0; i < 3; i++) do_write(8'h00, 32'hA550_0000 + i, 0, 0, 0, resp);
        aw_addr = 8'h00; aw_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0;
        check("mr_aw_held", aw_ready, 0);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        drops = 0;
        @(negedge clk);
        check_all_zero_after: begin
            check("mr_count", fifo_count, 0);
            check("mr_no_resp", b_valid, 0);
        end
        w_data = 32'hA500_00EE; w_valid = 1'b1;
        check("mr_w_ready", w_ready, 1);
        @(negedge clk);
        w_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mr_no_commit", b_valid, 0);
        aw_addr = 8'h00; aw_valid = 1'b1;
        check("mr_aw_ready", aw_ready, 1);
        @(negedge clk);
        aw_valid = 1'b0;
        check("mr_commit", {b_valid, b_resp}, 3'b100);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        mq.push_back(32'hA500_00EE);
        check_level("mr");

        // Randomized mix
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4, 5: a = 8'h00;
                6:                a = 8'h04;
                7:                a = 8'h08;
                8:                a = 8'h0C;
                default:          a = 8'($urandom_range(0, 255));
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 9) != 0) d[31:24] = 8'hA5;
            if (a[7:2] == 6'd2 && $urandom_range(0, 9) != 0) d[0] = 1'b0;
            op = $urandom_range(0, 99);
            if (op < 52)
                do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
            else if (op < 90)
                do_read(a, $urandom_range(0, 2), got);
            else
                do_both(($urandom_range(0, 7) == 0) ? 8'h08 : 8'h00, d,
                        ($urandom_range(0, 3) == 0) ? 8'h04 : 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
